// File: rtl/quad_step_decoder_if.sv
// Encoder-side bus of the quadrature decoder: raw phases and preload/clear
// controls in, position count and step/direction/error status out.
interface quad_step_decoder_if #(
    parameter int WIDTH = 8
);
    logic             a;
    logic             b;
    logic [WIDTH-1:0] d;
    logic             load;
    logic             err_clr;
    logic [WIDTH-1:0] qd;
    logic             dir;
    logic             step;
    logic             err;

    modport master (
        output a, b, d, load, err_clr,
        input  qd, dir, step, err
    );

    modport slave (
        input  a, b, d, load, err_clr,
        output qd, dir, step, err
    );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature decoder: synchronizes encoder phases a/b, decodes Gray steps into
// an up/down position count with direction, step strobe and sticky error flag.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_PRIME | synchronizer filling after reset; prev loaded on the last edge
// ST_RUN   | decoding prev -> s on every edge
module quad_step_decoder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               clear,
    quad_step_decoder_if.slave bus
);

    typedef enum logic {
        ST_PRIME,
        ST_RUN
    } state_t;

    localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [2:0]             prime_cnt;
    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             s;
    logic [1:0]             s_nxt;
    logic [1:0]             prev;
    logic                   prime_done;
    logic                   up;
    logic                   dn;
    logic                   ill;
    logic [WIDTH-1:0]       qd_r;
    logic                   dir_r;
    logic                   step_r;
    logic                   err_r;

    assign s     = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
    // Value the last synchronizer stage takes on this edge; prev primes from it
    // so a level held through reset is not mistaken for a transition.
    assign s_nxt = {sync_a[SYNC_STAGES-2], sync_b[SYNC_STAGES-2]};

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= ST_PRIME;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        prime_done = 1'b0;
        up         = 1'b0;
        dn         = 1'b0;
        ill        = 1'b0;
        case (state)
            ST_PRIME: begin
                if (prime_cnt == 3'd0) begin
                    state_nxt  = ST_RUN;
                    prime_done = 1'b1;
                end
            end
            ST_RUN: begin
                case ({prev, s})
                    4'b0001, 4'b0111, 4'b1110, 4'b1000: up  = 1'b1;
                    4'b0010, 4'b1011, 4'b1101, 4'b0100: dn  = 1'b1;
                    4'b0011, 4'b1100, 4'b0110, 4'b1001: ill = 1'b1;
                    default: ;
                endcase
            end
            default: state_nxt = ST_PRIME;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            sync_a    <= '0;
            sync_b    <= '0;
            prime_cnt <= PRIME_LAST;
            prev      <= 2'b00;
            qd_r      <= '0;
            dir_r     <= 1'b0;
            step_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], bus.a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], bus.b};

            if (state == ST_PRIME && prime_cnt != 3'd0) begin
                prime_cnt <= prime_cnt - 3'd1;
            end

            if (prime_done) begin
                prev <= s_nxt;
            end else if (state == ST_RUN) begin
                prev <= s;
            end

            step_r <= up | dn;
            if (up) begin
                dir_r <= 1'b1;
            end else if (dn) begin
                dir_r <= 1'b0;
            end

            if (bus.load) begin
                qd_r <= bus.d;
            end else if (up) begin
                qd_r <= qd_r + WIDTH'(1);
            end else if (dn) begin
                qd_r <= qd_r - WIDTH'(1);
            end

            if (ill) begin
                err_r <= 1'b1;
            end else if (bus.err_clr) begin
                err_r <= 1'b0;
            end
        end
    end

    assign bus.qd   = qd_r;
    assign bus.dir  = dir_r;
    assign bus.step = step_r;
    assign bus.err  = err_r;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: a vector table for Gray counting and
// wrap, plus hand sequences for priming, errors, load priority and reset.
module tb_quad_step_decoder;

    localparam int W = 8;
    localparam int N = 2;

    typedef struct {
        logic [1:0]   ab;
        logic [W-1:0] exp_qd;
        logic         exp_dir;
        logic         exp_err;
        int           exp_steps;
    } vec_t;

    logic clk;
    logic clear;
    int   n_checks;
    int   n_fail;
    int   step_cnt;
    vec_t vecs[14];

    quad_step_decoder_if #(.WIDTH(W)) ifc ();

    quad_step_decoder #(.WIDTH(W), .SYNC_STAGES(N)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ifc.step === 1'b1) step_cnt = step_cnt + 1;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ab(input logic [1:0] ab);
        ifc.a = ab[1];
        ifc.b = ab[0];
    endtask

    initial begin
        int base;
        n_checks = 0;
        n_fail   = 0;
        step_cnt = 0;

        for (int r = 0; r < 3; r++) begin
            vecs[4*r+0] = '{2'b01, W'(4*r+1), 1'b1, 1'b0, 4*r+1};
            vecs[4*r+1] = '{2'b11, W'(4*r+2), 1'b1, 1'b0, 4*r+2};
            vecs[4*r+2] = '{2'b10, W'(4*r+3), 1'b1, 1'b0, 4*r+3};
            vecs[4*r+3] = '{2'b00, W'(4*r+4), 1'b1, 1'b0, 4*r+4};
        end
        vecs[12] = '{2'b10, 8'hFF, 1'b0, 1'b0, 14};
        vecs[13] = '{2'b11, 8'hFE, 1'b0, 1'b0, 15};

        // Reset and prime with both phases held high
        clear = 1'b0;
        set_ab(2'b11);
        ifc.d = '0;
        ifc.load = 1'b0;
        ifc.err_clr = 1'b0;
        tick(3);
        check("reset_qd", ifc.qd, 0);
        check("reset_dir", ifc.dir, 0);
        check("reset_step", ifc.step, 0);
        check("reset_err", ifc.err, 0);
        clear = 1'b1;
        tick(10);
        check("prime_qd", ifc.qd, 0);
        check("prime_steps", step_cnt, 0);
        check("prime_err", ifc.err, 0);

        // Re-reset with ab=00 as the starting point for counting
        #2 clear = 1'b0;
        set_ab(2'b00);
        #2 clear = 1'b1;
        tick(10);
        step_cnt = 0;

        for (int i = 0; i < 14; i++) begin
            if (i == 12) begin
                ifc.d = 8'h00;
                ifc.load = 1'b1;
                tick(1);
                ifc.load = 1'b0;
                check("preload_zero", ifc.qd, 0);
                step_cnt = 13;
            end
            set_ab(vecs[i].ab);
            tick(6);
            check($sformatf("vec%0d_qd", i), ifc.qd, vecs[i].exp_qd);
            check($sformatf("vec%0d_dir", i), ifc.dir, vecs[i].exp_dir);
            check($sformatf("vec%0d_err", i), ifc.err, vecs[i].exp_err);
            check($sformatf("vec%0d_steps", i), step_cnt, vecs[i].exp_steps);
        end

        // Illegal 11->00
        base = step_cnt;
        set_ab(2'b00);
        tick(6);
        check("ill_err", ifc.err, 1);
        check("ill_qd", ifc.qd, 8'hFE);
        check("ill_steps", step_cnt, base);
        ifc.err_clr = 1'b1;
        tick(1);
        ifc.err_clr = 1'b0;
        check("errclr", ifc.err, 0);

        // 00->01 up, then 01->10 illegal with err_clr held through the decode edge
        set_ab(2'b01);
        tick(6);
        check("up_ff_qd", ifc.qd, 8'hFF);
        set_ab(2'b10);
        ifc.err_clr = 1'b1;
        tick(N + 1);
        ifc.err_clr = 1'b0;
        check("set_wins_err", ifc.err, 1);
        tick(4);
        check("set_wins_hold", ifc.err, 1);
        check("set_wins_qd", ifc.qd, 8'hFF);

        // Load priority over a coincident up step (10->00)
        ifc.d = 8'h10;
        ifc.load = 1'b1;
        tick(1);
        ifc.load = 1'b0;
        check("load_10", ifc.qd, 8'h10);
        set_ab(2'b00);
        tick(N);
        check("pre_decode_step", ifc.step, 0);
        ifc.d = 8'h80;
        ifc.load = 1'b1;
        tick(1);
        ifc.load = 1'b0;
        check("loadpri_qd", ifc.qd, 8'h80);
        check("loadpri_step", ifc.step, 1);
        check("loadpri_dir", ifc.dir, 1);
        tick(1);
        check("step_one_cycle", ifc.step, 0);
        set_ab(2'b01);
        tick(6);
        check("after_load_qd", ifc.qd, 8'h81);

        // Async reset mid-count
        ifc.d = 8'h05;
        ifc.load = 1'b1;
        tick(1);
        ifc.load = 1'b0;
        check("load_05", ifc.qd, 8'h05);
        #2 clear = 1'b0;
        #1;
        check("async_qd", ifc.qd, 0);
        check("async_dir", ifc.dir, 0);
        check("async_err", ifc.err, 0);
        set_ab(2'b11);
        #1 clear = 1'b1;
        base = step_cnt;
        for (int i = 0; i < N; i++) begin
            tick(1);
            check($sformatf("reprime_step%0d", i), ifc.step, 0);
        end
        tick(6);
        check("reprime_qd", ifc.qd, 0);
        check("reprime_steps", step_cnt, base);
        check("reprime_err", ifc.err, 0);
        set_ab(2'b10);
        tick(N);
        check("latency_early", ifc.step, 0);
        tick(1);
        check("latency_step", ifc.step, 1);
        check("first_step_qd", ifc.qd, 1);
        check("first_step_dir", ifc.dir, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
